// File: rtl/addersub_pkg.sv
// addersub_pkg: shared constants for the addersub adder/subtractor.
//   ADDSUB_WIDTH_DEFAULT - default operand/result width
//   MODE_ADD / MODE_SUB  - encodings of the mode input M
package addersub_pkg;

   localparam int unsigned ADDSUB_WIDTH_DEFAULT = 16;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage : addersub_pkg

// File: rtl/addersub_fa.sv
// addersub_fa: 1-bit full adder, one stage of the addersub ripple-carry chain.
// Ports:
//   a, b  - input operand bits
//   cin   - carry in from the previous stage
//   s     - sum bit
//   cout  - carry out to the next stage
module addersub_fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule : addersub_fa

// File: rtl/addersub.sv
// addersub: two's-complement adder/subtractor with registered outputs.
// The result is captured one clock after a, b and M are sampled; a new
// operation completes every cycle.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears all outputs
//   a      - operand A (minuend when subtracting)
//   b      - operand B (subtrahend when subtracting)
//   M      - mode: MODE_ADD (0) = a + b, MODE_SUB (1) = a - b
//   s      - registered result, modulo 2^WIDTH
//   co     - registered MSB carry-out (for subtract: 1 = no borrow)
//   ovf    - registered signed overflow; only present when ADDSUB_OVF_EN is defined
module addersub
   import addersub_pkg::*;
#(
   parameter int unsigned WIDTH = ADDSUB_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             M,
   output logic [WIDTH-1:0] s,
`ifdef ADDSUB_OVF_EN
   output logic             ovf,
`endif
   output logic             co
);

   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH:0]   w_carry;

   logic [WIDTH-1:0] r_s;
   logic             r_co;

   // Subtraction is a + ~b + 1: invert b and inject the +1 as the chain's carry-in.
   assign w_b_eff    = (M == MODE_SUB) ? ~b : b;
   assign w_carry[0] = M;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      addersub_fa u_fa (
         .a    (a[i]),
         .b    (w_b_eff[i]),
         .cin  (w_carry[i]),
         .s    (w_sum[i]),
         .cout (w_carry[i+1])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s  <= '0;
         r_co <= 1'b0;
      end else begin
         r_s  <= w_sum;
         r_co <= w_carry[WIDTH];
      end
   end

   assign s  = r_s;
   assign co = r_co;

`ifdef ADDSUB_OVF_EN
   logic w_ovf;
   logic r_ovf;

   // Overflow: both effective operands share a sign that the result does not.
   assign w_ovf = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else begin
         r_ovf <= w_ovf;
      end
   end

   assign ovf = r_ovf;
`endif

endmodule : addersub

// File: tb/tb_addersub.sv
// tb_addersub: self-checking bench for addersub (WIDTH = 16).
// Directed vectors plus randomized operations checked against an
// arithmetic reference model. Overflow checks are built when ADDSUB_OVF_EN
// is defined.
module tb_addersub;

   localparam int W = 16;

   logic          clk;
   logic          rst_n;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          M;
   logic [W-1:0]  s;
   logic          co;
`ifdef ADDSUB_OVF_EN
   logic          ovf;
`endif

   int checks;
   int failures;

   addersub #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .M     (M),
      .s     (s),
`ifdef ADDSUB_OVF_EN
      .ovf   (ovf),
`endif
      .co    (co)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain integer arithmetic on the unsigned/signed values.
   function automatic logic [W-1:0] ref_s(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic m);
      longint r;
      r = m ? (longint'(x) - longint'(y)) : (longint'(x) + longint'(y));
      if (r < 0) r = r + (longint'(1) << W);
      return W'(r % (longint'(1) << W));
   endfunction

   function automatic logic ref_co(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic m);
      if (m) return longint'(x) >= longint'(y);
      return (longint'(x) + longint'(y)) >= (longint'(1) << W);
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic m);
      longint sx, sy, r;
      sx = x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
      sy = y[W-1] ? longint'(y) - (longint'(1) << W) : longint'(y);
      r  = m ? sx - sy : sx + sy;
      return (r > ((longint'(1) << (W-1)) - 1)) || (r < -(longint'(1) << (W-1)));
   endfunction

   // Drive operands away from the edge, then sample just after the capturing edge.
   task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
      @(negedge clk);
      a = x;
      b = y;
      M = m;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a = 16'd5;
      b = 16'd2;
      M = 1'b0;
      #1;
      checks++;
      if (s !== 16'h0000 || co !== 1'b0) begin
         failures++;
         $display("FAIL reset_async: s=%h co=%b, required s=0000 co=0", s, co);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (s !== 16'd7 || co !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: s=%h co=%b, required s=0007 co=0", s, co);
      end
   endtask

   task automatic test_add();
      logic [W-1:0] va [4];
      logic [W-1:0] vb [4];
      logic [W-1:0] es [4];
      logic         ec [4];
      va = '{16'd5, 16'd15, 16'd205, 16'hFFFF};
      vb = '{16'd2, 16'd20, 16'd200, 16'd1};
      es = '{16'd7, 16'd35, 16'd405, 16'h0000};
      ec = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         drive_op(va[i], vb[i], 1'b0);
         checks++;
         if (s !== es[i] || co !== ec[i]) begin
            failures++;
            $display("FAIL add[%0d]: s=%h co=%b, required s=%h co=%b", i, s, co, es[i], ec[i]);
         end
      end
   endtask

   task automatic test_sub_no_borrow();
      logic [W-1:0] va [3];
      logic [W-1:0] vb [3];
      logic [W-1:0] es [3];
      va = '{16'd5, 16'd62, 16'd100};
      vb = '{16'd2, 16'd23, 16'd100};
      es = '{16'd3, 16'd39, 16'd0};
      for (int i = 0; i < 3; i++) begin
         drive_op(va[i], vb[i], 1'b1);
         checks++;
         if (s !== es[i] || co !== 1'b1) begin
            failures++;
            $display("FAIL sub_no_borrow[%0d]: s=%h co=%b, required s=%h co=1", i, s, co, es[i]);
         end
      end
   endtask

   task automatic test_sub_borrow();
      logic [W-1:0] va [3];
      logic [W-1:0] vb [3];
      logic [W-1:0] es [3];
      va = '{16'd1, 16'd58, 16'd59};
      vb = '{16'd2, 16'd92, 16'd225};
      es = '{16'hFFFF, 16'hFFDE, 16'hFF5A};
      for (int i = 0; i < 3; i++) begin
         drive_op(va[i], vb[i], 1'b1);
         checks++;
         if (s !== es[i] || co !== 1'b0) begin
            failures++;
            $display("FAIL sub_borrow[%0d]: s=%h co=%b, required s=%h co=0", i, s, co, es[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         drive_op(16'd55, 16'd28, 1'b0);
         checks++;
         if (s !== 16'd83 || co !== 1'b0) begin
            failures++;
            $display("FAIL b2b_add[%0d]: s=%h co=%b, required s=0053 co=0", i, s, co);
         end
         drive_op(16'd55, 16'd68, 1'b1);
         checks++;
         if (s !== 16'hFFF3 || co !== 1'b0) begin
            failures++;
            $display("FAIL b2b_sub[%0d]: s=%h co=%b, required s=fff3 co=0", i, s, co);
         end
      end
   endtask

   task automatic test_reset_mid();
      drive_op(16'd205, 16'd200, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (s !== 16'h0000 || co !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_async: s=%h co=%b, required s=0000 co=0", s, co);
      end
      drive_op(16'hFFFF, 16'd1, 1'b0);
      checks++;
      if (s !== 16'h0000 || co !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold: s=%h co=%b, required s=0000 co=0", s, co);
      end
      @(negedge clk);
      rst_n = 1'b1;
      a = 16'd62;
      b = 16'd23;
      M = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (s !== 16'd39 || co !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_release: s=%h co=%b, required s=0027 co=1", s, co);
      end
   endtask

`ifdef ADDSUB_OVF_EN
   task automatic test_ovf();
      drive_op(16'h7FFF, 16'd1, 1'b0);
      checks++;
      if (s !== 16'h8000 || ovf !== 1'b1 || co !== 1'b0) begin
         failures++;
         $display("FAIL ovf_add: s=%h ovf=%b co=%b, required s=8000 ovf=1 co=0", s, ovf, co);
      end
      drive_op(16'h8000, 16'd1, 1'b1);
      checks++;
      if (s !== 16'h7FFF || ovf !== 1'b1 || co !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sub: s=%h ovf=%b co=%b, required s=7fff ovf=1 co=1", s, ovf, co);
      end
      drive_op(16'd5, 16'd2, 1'b0);
      checks++;
      if (ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_none: ovf=%b, required 0", ovf);
      end
   endtask
`endif

   task automatic test_random();
      logic [W-1:0] x, y;
      logic         m;
      for (int i = 0; i < 300; i++) begin
         x = W'($urandom);
         y = W'($urandom);
         // Bias some operands toward the extremes to hit carry/overflow edges.
         if ((i % 7) == 0) x = 16'hFFFF - W'($urandom_range(0, 3));
         if ((i % 11) == 0) y = W'($urandom_range(0, 3)) ^ 16'h8000;
         m = 1'($urandom);
         drive_op(x, y, m);
         checks++;
         if (s !== ref_s(x, y, m) || co !== ref_co(x, y, m)) begin
            failures++;
            $display("FAIL random[%0d] a=%h b=%h M=%b: s=%h co=%b, required s=%h co=%b",
                     i, x, y, m, s, co, ref_s(x, y, m), ref_co(x, y, m));
         end
`ifdef ADDSUB_OVF_EN
         checks++;
         if (ovf !== ref_ovf(x, y, m)) begin
            failures++;
            $display("FAIL random_ovf[%0d] a=%h b=%h M=%b: ovf=%b, required %b",
                     i, x, y, m, ovf, ref_ovf(x, y, m));
         end
`endif
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_add();
      test_sub_no_borrow();
      test_sub_borrow();
      test_back_to_back();
`ifdef ADDSUB_OVF_EN
      test_ovf();
`endif
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_addersub
